// File: rtl/dm_responder.sv
// dm_responder: single-port 32-bit data memory answering one load/store request at a time.
// Latency: Ack rises WAIT_CYCLES+1 cycles after the edge that captures Req; one access per WAIT_CYCLES+2 cycles.
// Backpressure: none queued; Req is sampled only while idle (Busy=0) and ignored otherwise.
//
// Ports:
//   Clk, Reset          rising-edge clock, synchronous active-high reset (also clears the memory)
//   Req                 request strobe, sampled only in IDLE
//   WrEn, Byte, HByte   store/load select and access size (Byte wins over HByte, neither = word)
//   MemAddr, DataIn     byte address and right-aligned store data
//   Ack                 one-cycle response strobe
//   DataOut, AlignErr   load data / misalignment flag, both forced to 0 whenever Ack=0
//   Busy                high while the FSM is not in IDLE
//
// Option: define DM_RESPONDER_ALIGN_CHECK_EN to flag misaligned halfword/word accesses with
// AlignErr, suppress their write and return zero data. Without it AlignErr stays 0 and the
// low address bits below the access size are simply ignored.

module dm_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WrEn,
  input  logic        Byte,
  input  logic        HByte,
  input  logic [31:0] MemAddr,
  input  logic [31:0] DataIn,
  output logic        Ack,
  output logic [31:0] DataOut,
  output logic        Busy,
  output logic        AlignErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Last value of the wait counter before moving to RESP. Unused when WAIT_CYCLES is 0
  // because IDLE then jumps straight to RESP.
  localparam int          WAIT_LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_LAST_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;

  // Request fields frozen at capture; the access only ever looks at these.
  logic        c_wr;
  logic        c_byte;
  logic        c_hbyte;
  logic [31:0] c_addr;
  logic [31:0] c_data;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word;
  logic          is_half;
  logic          is_word;
  logic          align_bad;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   load_val;
  logic [31:0]   merged;

  // Address bits above the array simply wrap; they are folded here only so they
  // are visibly consumed.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^c_addr[31:AW+2];

  assign word_idx = c_addr[AW+1:2];
  assign cur_word = mem[word_idx];
  assign is_half  = !c_byte && c_hbyte;
  assign is_word  = !c_byte && !c_hbyte;

`ifdef DM_RESPONDER_ALIGN_CHECK_EN
  assign align_bad = (is_half && c_addr[0]) || (is_word && (c_addr[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif

  // Little-endian lane selection: byte lane = addr[1:0], halfword lane = addr[1].
  // In the unchecked build a halfword ignores addr[0] and a word ignores addr[1:0].
  always_comb begin
    lane_b   = cur_word[{c_addr[1:0], 3'b000} +: 8];
    lane_h   = cur_word[{c_addr[1], 4'b0000} +: 16];
    load_val = cur_word;
    merged   = cur_word;
    if (c_byte) begin
      load_val = {{24{lane_b[7]}}, lane_b};
      merged[{c_addr[1:0], 3'b000} +: 8] = c_data[7:0];
    end else if (c_hbyte) begin
      load_val = {{16{lane_h[15]}}, lane_h};
      merged[{c_addr[1], 4'b0000} +: 16] = c_data[15:0];
    end else begin
      load_val = cur_word;
      merged   = c_data;
    end
  end

  assign Busy = (state != IDLE);

  // Control FSM. Ack/DataOut/AlignErr are registered on the edge that ends RESP, which
  // is the same edge a store commits on; a reset landing on that edge therefore kills
  // both the response and the write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      Ack      <= 1'b0;
      DataOut  <= 32'd0;
      AlignErr <= 1'b0;
      c_wr     <= 1'b0;
      c_byte   <= 1'b0;
      c_hbyte  <= 1'b0;
      c_addr   <= 32'd0;
      c_data   <= 32'd0;
    end else begin
      Ack      <= 1'b0;
      DataOut  <= 32'd0;
      AlignErr <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            c_wr     <= WrEn;
            c_byte   <= Byte;
            c_hbyte  <= HByte;
            c_addr   <= MemAddr;
            c_data   <= DataIn;
            wait_cnt <= 4'd0;
            state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          Ack      <= 1'b1;
          AlignErr <= align_bad;
          // Stores and rejected accesses return zero data.
          DataOut  <= (c_wr || align_bad) ? 32'd0 : load_val;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage. Reads see the pre-store contents during RESP; the store lands on the
  // edge that ends RESP and touches only the addressed lanes (held in merged).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if ((state == RESP) && c_wr && !align_bad) begin
      mem[word_idx] <= merged;
    end
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted between request capture and response (legal 0..15).
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array (power of two).
REQ-003 Port Clk  input  1  rising-edge clock, the block's only clock.
REQ-004 Port Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 Port Req  input  1  initiator request strobe, sampled only in IDLE.
REQ-006 Port WrEn  input  1  1 = store, 0 = load.
REQ-007 Port Byte  input  1  byte-size access; has priority over HByte.
REQ-008 Port HByte  input  1  halfword-size access when Byte=0.
REQ-009 Port MemAddr  input  32  byte address.
REQ-010 Port DataIn  input  32  store data, right-aligned.
REQ-011 Port Ack  output  1  one-cycle response strobe.
REQ-012 Port DataOut  output  32  load data, valid only while Ack=1.
REQ-013 Port Busy  output  1  high whenever state is not IDLE.
REQ-014 Port AlignErr  output  1  misaligned-access flag, valid only while Ack=1.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP, registered.
REQ-016 IDLE with Req=1 SHALL capture WrEn, Byte, HByte, MemAddr and DataIn, then go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-017 WAIT SHALL count WAIT_CYCLES cycles with a counter cleared on entry, then go to RESP.
REQ-018 RESP SHALL last exactly one cycle with Ack=1, then return to IDLE.
REQ-019 Ack SHALL rise exactly WAIT_CYCLES+1 cycles after the edge that sampled Req; throughput is one access per WAIT_CYCLES+2 cycles.
REQ-020 Req SHALL be ignored in WAIT and RESP; no queuing.
REQ-021 Captured request fields SHALL be used for the access; input changes after capture SHALL have no effect.
REQ-022 Word index SHALL be MemAddr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-023 Lanes are little-endian: byte lane = MemAddr[1:0], halfword lane = MemAddr[1].
REQ-024 Store SHALL commit on the rising edge that ends the RESP cycle, modifying only the addressed lanes.
REQ-025 Byte/halfword loads SHALL return sign-extended data; word loads the full word.
REQ-026 Load data SHALL reflect memory contents as of the RESP cycle; DataOut SHALL be 0 when Ack=0.
REQ-027 Store response SHALL drive DataOut=0.

Reset
REQ-028 Reset=1 SHALL force IDLE, clear the wait counter, and drive Ack=0, Busy=0, AlignErr=0, DataOut=0 on the next edge.
REQ-029 Reset SHALL clear every memory word to 0x00000000.
REQ-030 Reset during WAIT or RESP SHALL abort the access: no Ack and no write.
REQ-031 Reset SHALL take priority over Req in the same cycle.

Configuration
REQ-032 Macro DM_RESPONDER_ALIGN_CHECK_EN SHALL enable alignment checking.
REQ-033 Defined: halfword with MemAddr[0]=1 or word with MemAddr[1:0]!=0 SHALL give AlignErr=1 with Ack, suppress the write and return DataOut=0.
REQ-034 Undefined: AlignErr SHALL be constant 0; halfword ignores MemAddr[0]; word ignores MemAddr[1:0].

Verification
REQ-035 WAIT_CYCLES=2: word store 0xDEADBEEF @0x10, then word load @0x10 -> Ack 3 cycles after each Req, DataOut=0xDEADBEEF.
REQ-036 After REQ-035 write: byte store 0x7F @0x13, then byte load @0x13 -> 0x0000007F; word load @0x10 -> 0x7FADBEEF; byte load @0x11 -> 0xFFFFFFBE.
REQ-037 Halfword load @0x12 after REQ-036 -> 0x00007FAD; Req held high through RESP -> second Ack exactly 4 cycles after the first.
REQ-038 Store 0x12345678 @0x14, Reset asserted during WAIT -> no Ack; later load @0x14 -> 0x00000000.
REQ-039 Macro defined: halfword store @0x21 -> Ack with AlignErr=1, memory unchanged; macro undefined: same store writes lane MemAddr[1]=0, AlignErr=0.
REQ-040 WAIT_CYCLES=0, DEPTH_WORDS=1024: word store @0x1004 then load @0x0004 -> same data (wrap), Ack 1 cycle after each Req.
